// File: rtl/instr_sequencer.sv
// Registered multi-cycle instruction sequencer: accepts one opcode per handshake and
// drives datapath strobes from a four-state FSM, sequencing two-phase memory moves.
module instr_sequencer #(
   parameter int INSTR_WIDTH  = 5,
   parameter int OP_WIDTH     = 4,
   parameter int TWO_CYCLE_EN = 1,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   INSTR_VALID,
   input  logic [INSTR_WIDTH-1:0] INSTRUCTION,
   output logic                   INSTR_READY,
   output logic                   RESET_INSTR,
   output logic                   MEM_SEL,
   output logic                   MUX_SEL,
   output logic                   ACC_FROM_RAM,
   output logic                   CE_R0,
   output logic                   CE_ACC,
   output logic                   REG_WR,
   output logic                   CE_RAM,
   output logic                   CE_PC,
   output logic [OP_WIDTH-1:0]    OP,
   output logic                   ILLEGAL,
   output logic [CNT_WIDTH-1:0]   RETIRED,
   output logic [1:0]             STATE_DBG
);

   // Handshake: an opcode is taken on a rising CLK edge where INSTR_VALID && INSTR_READY;
   // INSTR_READY depends only on the state (low only in the address phase of a move).

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      MEM1 = 2'd2,
      MEM2 = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic       accept;
   logic       hi_bits;
   logic [4:0] low5;

   logic [3:0] d_op;
   logic       d_ce_acc, d_reg_wr, d_mux_sel, d_reset, d_ce_pc, d_illegal, d_mem, d_mem_wr;

   logic                 mem_wr_q, n_mem_wr;
   logic [OP_WIDTH-1:0]  n_op;
   logic                 n_reset, n_mem_sel, n_mux_sel, n_acc_from_ram, n_ce_r0;
   logic                 n_ce_acc, n_reg_wr, n_ce_ram, n_ce_pc, n_illegal;
   logic                 retire_now;
   logic [CNT_WIDTH-1:0] n_retired;

   assign INSTR_READY = (state_q != MEM1);
   assign accept      = INSTR_VALID & INSTR_READY;
   assign STATE_DBG   = state_q;

   // Opcode decode; any bit above [4] marks the opcode illegal.
   always_comb begin
      hi_bits   = ((INSTRUCTION >> 5) != '0);
      low5      = INSTRUCTION[4:0];
      d_op      = 4'h0;
      d_ce_acc  = 1'b0;
      d_reg_wr  = 1'b0;
      d_mux_sel = 1'b0;
      d_reset   = 1'b0;
      d_ce_pc   = 1'b0;
      d_illegal = 1'b0;
      d_mem     = 1'b0;
      d_mem_wr  = low5[0];
      if (hi_bits) begin
         d_illegal = 1'b1;
      end else if (low5 <= 5'h09) begin
         d_op     = low5[3:0];
         d_ce_acc = 1'b1;
      end else begin
         case (low5)
            5'h0A: begin
               d_op     = 4'hB;
               d_ce_acc = 1'b1;
            end
            5'h0B: d_reg_wr = 1'b1;
            5'h0C: ;
            5'h0D: begin
               d_mux_sel = 1'b1;
               d_ce_acc  = 1'b1;
            end
            5'h0E, 5'h0F: d_reset = 1'b1;
            5'h10, 5'h11: begin
               if (TWO_CYCLE_EN != 0) d_mem = 1'b1;
               else                   d_illegal = 1'b1;
            end
            5'h14: d_ce_pc = 1'b1;
            default: d_illegal = 1'b1;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = IDLE;
      case (state_q)
         MEM1:    state_d = MEM2;
         default: begin
            if (accept) state_d = d_mem ? MEM1 : EXEC;
            else        state_d = IDLE;
         end
      endcase
   end

   // Next values of the registered control vector for the cycle after this edge.
   always_comb begin
      n_op           = '0;
      n_reset        = 1'b0;
      n_mem_sel      = 1'b0;
      n_mux_sel      = 1'b0;
      n_acc_from_ram = 1'b0;
      n_ce_r0        = 1'b0;
      n_ce_acc       = 1'b0;
      n_reg_wr       = 1'b0;
      n_ce_ram       = 1'b0;
      n_ce_pc        = 1'b0;
      n_illegal      = 1'b0;
      n_mem_wr       = mem_wr_q;
      if (state_q == MEM1) begin
         n_mem_sel = 1'b1;
         if (mem_wr_q) begin
            n_ce_ram = 1'b1;
         end else begin
            n_acc_from_ram = 1'b1;
            n_ce_acc       = 1'b1;
         end
      end else if (accept) begin
         n_mem_wr = d_mem & d_mem_wr;
         if (d_mem) begin
            n_mem_sel = 1'b1;
         end else begin
            n_op[3:0] = d_op;
            n_ce_acc  = d_ce_acc;
            n_reg_wr  = d_reg_wr;
            n_mux_sel = d_mux_sel;
            n_reset   = d_reset;
            n_ce_pc   = d_ce_pc;
            n_illegal = d_illegal;
         end
      end
      retire_now = ((state_q == EXEC) && !ILLEGAL) || (state_q == MEM2);
      n_retired  = retire_now ? RETIRED + CNT_WIDTH'(1) : RETIRED;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         OP           <= '0;
         RESET_INSTR  <= 1'b0;
         MEM_SEL      <= 1'b0;
         MUX_SEL      <= 1'b0;
         ACC_FROM_RAM <= 1'b0;
         CE_R0        <= 1'b0;
         CE_ACC       <= 1'b0;
         REG_WR       <= 1'b0;
         CE_RAM       <= 1'b0;
         CE_PC        <= 1'b0;
         ILLEGAL      <= 1'b0;
         RETIRED      <= '0;
         mem_wr_q     <= 1'b0;
      end else begin
         OP           <= n_op;
         RESET_INSTR  <= n_reset;
         MEM_SEL      <= n_mem_sel;
         MUX_SEL      <= n_mux_sel;
         ACC_FROM_RAM <= n_acc_from_ram;
         CE_R0        <= n_ce_r0;
         CE_ACC       <= n_ce_acc;
         REG_WR       <= n_reg_wr;
         CE_RAM       <= n_ce_ram;
         CE_PC        <= n_ce_pc;
         ILLEGAL      <= n_illegal;
         RETIRED      <= n_retired;
         mem_wr_q     <= n_mem_wr;
      end
   end

endmodule
